// File: rtl/fp16_dot_sequencer_if.sv
// Bus bundle between fp16_dot_sequencer, its operand source, the shared
// FP16 multiplier/adder, and the result consumer.
// slave  : view taken by the sequencer itself
// master : view taken by the surrounding logic (or a testbench)
interface fp16_dot_sequencer_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] vec_len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic [15:0]      mul_a;
  logic [15:0]      mul_b;
  logic [15:0]      mul_result;
  logic [15:0]      add_a;
  logic [15:0]      add_b;
  logic [15:0]      add_result;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic             ovf;

  modport slave (
    input  start, vec_len, in_valid, in_a, in_b, mul_result, add_result, out_ready,
    output busy, in_ready, mul_a, mul_b, add_a, add_b, out_valid, out_data, ovf
  );

  modport master (
    output start, vec_len, in_valid, in_a, in_b, mul_result, add_result, out_ready,
    input  busy, in_ready, mul_a, mul_b, add_a, add_b, out_valid, out_data, ovf
  );
endinterface

// File: rtl/fp16_dot_sequencer.sv
// FP16 dot-product sequencer. Time-shares one external combinational FP16
// multiplier and one external FP16 adder; this block only sequences operands
// and registers their results (no rounding or normalisation here).
// Optional build macro: FP16_DOT_ZERO_SKIP_EN -- pairs with a +/-0 operand
// bypass the MUL/ADD states and cost a single FETCH cycle.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; busy=0
// FETCH | in_ready=1, waiting for an operand pair
// MUL   | product register captures mul_result
// ADD   | accumulator captures add_result, element counter advances
// DONE  | out_valid=1 with out_data=acc until out_ready
module fp16_dot_sequencer #(
  parameter int LEN_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  fp16_dot_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_MUL   = 3'd2,
    S_ADD   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_op_a;
  logic [15:0]      r_op_b;
  logic [15:0]      r_prod;
  logic [15:0]      r_acc;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic             r_ovf;

  logic             w_last;
  logic             w_zero;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_busy;

  // Exact terminal-count compare: len is never 0 while counting, so len-1
  // cannot underflow and a full 2^LEN_W-1 job never wraps.
  assign w_last = (r_cnt == (r_len - LEN_ONE));

`ifdef FP16_DOT_ZERO_SKIP_EN
  assign w_zero = (bus.in_a[14:0] == 15'd0) || (bus.in_b[14:0] == 15'd0);
`else
  assign w_zero = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = (bus.vec_len != '0) ? S_FETCH : S_DONE;
        end
      end
      S_FETCH: begin
        if (bus.in_valid) begin
          if (w_zero) begin
            w_state_nxt = w_last ? S_DONE : S_FETCH;
          end else begin
            w_state_nxt = S_MUL;
          end
        end
      end
      S_MUL:   w_state_nxt = S_ADD;
      S_ADD:   w_state_nxt = w_last ? S_DONE : S_FETCH;
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Moore handshake outputs
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE:  w_busy      = 1'b0;
      S_FETCH: w_in_ready  = 1'b1;
      S_DONE:  w_out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers: operands, product, accumulator, counters, sticky ovf
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_a <= 16'h0000;
      r_op_b <= 16'h0000;
      r_prod <= 16'h0000;
      r_acc  <= 16'h0000;
      r_cnt  <= '0;
      r_len  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_acc <= 16'h0000;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            if (bus.vec_len != '0) begin
              r_len <= bus.vec_len;
            end
          end
        end
        S_FETCH: begin
          if (bus.in_valid) begin
            r_op_a <= bus.in_a;
            r_op_b <= bus.in_b;
            // A skipped pair contributes nothing; it only consumes a count.
            if (w_zero) begin
              r_cnt <= r_cnt + LEN_ONE;
            end
          end
        end
        S_MUL: begin
          r_prod <= bus.mul_result;
          if (bus.mul_result[14:10] == 5'h1F) begin
            r_ovf <= 1'b1;
          end
        end
        S_ADD: begin
          r_acc <= bus.add_result;
          r_cnt <= r_cnt + LEN_ONE;
          if (bus.add_result[14:10] == 5'h1F) begin
            r_ovf <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = w_busy;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.mul_a     = r_op_a;
  assign bus.mul_b     = r_op_b;
  assign bus.add_a     = r_acc;
  assign bus.add_b     = r_prod;
  assign bus.out_data  = r_acc;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_fp16_dot_sequencer.sv
// Testbench for fp16_dot_sequencer: behavioural FP16 multiplier/adder built
// on real arithmetic, and a job-level reference model over queues of pairs.
module tb_fp16_dot_sequencer;
  localparam int LEN_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [15:0] pa[$];
  logic [15:0] pb[$];

  fp16_dot_sequencer_if #(.LEN_W(LEN_W)) bus ();

  fp16_dot_sequencer #(.LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  // Exponent 31 is treated as a huge finite value so products never go NaN.
  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    if (e == 0)       m = real'(int'(h[9:0])) * pow2(-24);
    else if (e == 31) m = 131072.0;
    else              m = (1.0 + real'(int'(h[9:0])) / 1024.0) * pow2(e - 15);
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    logic s;
    real  m;
    int   e;
    int   f;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 0;
    if (m == 0.0)      return {s, 15'd0};
    if (m >= 65520.0)  return {s, 15'h7C00};
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0 && e > -14) begin m = m * 2.0; e--; end
    if (m < 1.0) begin
      f = $rtoi(m * 1024.0 + 0.5);
      if (f >= 1024) return {s, 5'd1, 10'd0};
      return {s, 5'd0, 10'(f)};
    end
    f = $rtoi((m - 1.0) * 1024.0 + 0.5);
    if (f >= 1024) begin f = 0; e++; end
    if (e > 15) return {s, 15'h7C00};
    return {s, 5'(e + 15), 10'(f)};
  endfunction

  function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
    return r2h(h2r(a) * h2r(b));
  endfunction

  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    return r2h(h2r(a) + h2r(b));
  endfunction

  always_comb bus.mul_result = fp_mul(bus.mul_a, bus.mul_b);
  always_comb bus.add_result = fp_add(bus.add_a, bus.add_b);

  function automatic logic [15:0] rnd_h();
    if ($urandom_range(0, 4) == 0) return {1'($urandom_range(0, 1)), 15'd0};
    return {1'($urandom_range(0, 1)), 5'($urandom_range(10, 18)), 10'($urandom)};
  endfunction

  // Job-level model: sum of rounded products, sticky exponent-31 flag, and
  // cycles from start to out_valid with in_valid held high.
  task automatic model_job(input int n, output logic [15:0] res, output logic ov, output int lat);
    logic [15:0] p;
    res = 16'h0000;
    ov  = 1'b0;
    lat = 1;
    for (int i = 0; i < n; i++) begin
`ifdef FP16_DOT_ZERO_SKIP_EN
      if (pa[i][14:0] == 15'd0 || pb[i][14:0] == 15'd0) begin
        lat = lat + 1;
        continue;
      end
`endif
      p   = fp_mul(pa[i], pb[i]);
      ov  = ov | (p[14:10] == 5'h1F);
      res = fp_add(res, p);
      ov  = ov | (res[14:10] == 5'h1F);
      lat = lat + 3;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Starts a job over pa/pb and runs until out_valid (left pending).
  task automatic run_job(input int n, input bit gaps, input string tag);
    logic [15:0] exp_res;
    logic        exp_ovf;
    int          exp_lat;
    int          idx;
    int          edges;
    bit          acc_now;
    bit          done;
    bit          saw_ready;
    idx = 0; edges = 0; done = 0; saw_ready = 0;
    model_job(n, exp_res, exp_ovf, exp_lat);
    bus.start    = 1'b1;
    bus.vec_len  = LEN_W'(n);
    bus.in_valid = (n > 0);
    if (n > 0) begin bus.in_a = pa[0]; bus.in_b = pb[0]; end
    while (!done && edges < 5000) begin
      acc_now = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      edges++;
      bus.start = 1'b0;
      if (edges == 1) begin
        chk({tag, "_ovf_cleared"}, 32'(bus.ovf), 32'd0);
        chk({tag, "_in_ready_first"}, 32'(bus.in_ready), 32'(n > 0));
      end
      if (bus.in_ready) saw_ready = 1;
      if (acc_now) idx++;
      if (idx < n) begin
        bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        bus.in_a     = pa[idx];
        bus.in_b     = pb[idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.out_valid) done = 1;
    end
    bus.in_valid = 1'b0;
    chk({tag, "_timeout"}, 32'(done), 32'd1);
    chk({tag, "_out_data"}, 32'(bus.out_data), 32'(exp_res));
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
    chk({tag, "_pairs_taken"}, 32'(idx), 32'(n));
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    if (!gaps) chk({tag, "_latency"}, 32'(edges), 32'(exp_lat));
    if (n == 0) chk({tag, "_no_in_ready"}, 32'(saw_ready), 32'd0);
  endtask

  task automatic finish_out(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_ovf"},       32'(bus.ovf),       32'd0);
    chk({tag, "_buses"},     {bus.mul_a, bus.mul_b}, 32'd0);
    chk({tag, "_acc"},       {bus.add_a, bus.add_b}, 32'd0);
    chk({tag, "_out_data"},  32'(bus.out_data),  32'd0);
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.vec_len = '0; bus.in_valid = 1'b0;
    bus.in_a = 16'h0; bus.in_b = 16'h0; bus.out_ready = 1'b0;

    // Reset values, before any clock edge
    #3;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Basic two-element job, in_valid held high
    pa = '{16'h3C00, 16'h4000}; pb = '{16'h4000, 16'h4200};
    run_job(2, 0, "basic");
    chk("basic_literal", 32'(bus.out_data), 32'h4800);

    // Backpressure: output held, start ignored while busy
    for (int i = 0; i < 10; i++) begin
      bus.start = (i % 3 == 0); bus.vec_len = LEN_W'(3);
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_data", 32'(bus.out_data), 32'h4800);
      chk("bp_busy", 32'(bus.busy), 32'd1);
    end
    bus.start = 1'b0;
    finish_out("bp");
    @(posedge clk); #1;
    chk("bp_start_not_queued", 32'(bus.busy), 32'd0);

    // Zero-length job
    pa.delete(); pb.delete();
    run_job(0, 0, "zero_len");
    chk("zero_len_literal", 32'(bus.out_data), 32'h0000);
    finish_out("zero_len");

    // Overflow sets sticky flag; next start clears it
    pa = '{16'h7800}; pb = '{16'h7800};
    run_job(1, 0, "ovf");
    chk("ovf_literal", 32'(bus.ovf), 32'd1);
    finish_out("ovf");
    pa = '{16'h3C00}; pb = '{16'h4000};
    run_job(1, 0, "after_ovf");
    finish_out("after_ovf");

    // Zero-operand pairs
    pa = '{16'h0000, 16'h8000, 16'h4000}; pb = '{16'h4000, 16'h3C00, 16'h4000};
    run_job(3, 0, "zskip");
    chk("zskip_literal", 32'(bus.out_data), 32'h4400);
    finish_out("zskip");

    // Async reset during MUL of element 3 of 5
    pa = '{16'h3C00, 16'h4000, 16'h4200, 16'h3C00, 16'h4400};
    pb = '{16'h4000, 16'h4000, 16'h3C00, 16'h3C00, 16'h3C00};
    begin
      int idx;
      int edges;
      bit acc_now;
      idx = 0; edges = 0;
      bus.start = 1'b1; bus.vec_len = LEN_W'(5);
      bus.in_valid = 1'b1; bus.in_a = pa[0]; bus.in_b = pb[0];
      while (idx < 3 && edges < 100) begin
        acc_now = bus.in_valid && bus.in_ready;
        @(posedge clk); #1;
        edges++;
        bus.start = 1'b0;
        if (acc_now) idx++;
        if (idx < 5) begin bus.in_a = pa[idx]; bus.in_b = pb[idx]; end
      end
      bus.in_valid = 1'b0;
      chk("arst_reached_mul", 32'(idx), 32'd3);
      chk("arst_op_latched", {bus.mul_a, bus.mul_b}, {pa[2], pb[2]});
      #2 rst = 1'b1;
      #1;
      chk_all_zero("arst");
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
    end
    pa = '{16'h3C00}; pb = '{16'h3C00};
    run_job(1, 0, "post_arst");
    chk("post_arst_literal", 32'(bus.out_data), 32'h3C00);
    finish_out("post_arst");

    // Randomised jobs, alternating continuous and gappy operand streams
    for (int j = 0; j < 8; j++) begin
      n = $urandom_range(1, 12);
      pa.delete(); pb.delete();
      for (int i = 0; i < n; i++) begin
        pa.push_back(rnd_h());
        pb.push_back(rnd_h());
      end
      run_job(n, bit'(j % 2), $sformatf("rand%0d", j));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      finish_out($sformatf("rand%0d", j));
    end

    // Maximum-length job: counter must reach 254 without wrapping
    pa.delete(); pb.delete();
    for (int i = 0; i < 255; i++) begin
      pa.push_back(16'h3C00);
      pb.push_back(16'h3C00);
    end
    run_job(255, 0, "maxlen");
    chk("maxlen_literal", 32'(bus.out_data), 32'h5BF8);
    finish_out("maxlen");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
